// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_address, mem_write_data, mem_write_enable,
        input  mem_read_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_address, mem_write_data, mem_write_enable,
        output mem_read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory between fetch and data ports.
// Data has priority; a consecutive-grant counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int MAX_CONSEC = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_CONSEC + 1);

    logic [CW-1:0] cnt;
    logic          force_if;
    logic          d_gnt;
    logic          i_gnt;
    logic          misalign;

    // Grants are suppressed while reset is held so nothing reaches memory.
    assign force_if = bus.if_req_valid && (cnt == CW'(MAX_CONSEC));
    assign d_gnt    = rst_n && bus.d_req_valid && !force_if;
    assign i_gnt    = rst_n && bus.if_req_valid && !d_gnt;
    assign misalign = bus.d_req_addr[1:0] != 2'b00;

    assign bus.d_req_ready      = d_gnt;
    assign bus.if_req_ready     = i_gnt;
    assign bus.mem_write_data   = bus.d_req_wdata;
    assign bus.mem_write_enable = d_gnt && bus.d_req_we && !misalign;

    always_comb begin
        bus.mem_address = 32'h0;
        if (d_gnt)
            bus.mem_address = bus.d_req_addr;
        else if (i_gnt)
            bus.mem_address = bus.if_req_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_data  <= 32'h0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rsp_data   <= 32'h0;
            bus.d_rsp_err    <= 1'b0;
        end else begin
            bus.if_rsp_valid <= i_gnt;
            bus.if_rsp_data  <= i_gnt ? bus.mem_read_data : 32'h0;
            bus.d_rsp_valid  <= d_gnt;
            bus.d_rsp_err    <= d_gnt && misalign;
            if (d_gnt && !bus.d_req_we && !misalign)
                bus.d_rsp_data <= bus.mem_read_data;
            else
                bus.d_rsp_data <= 32'h0;
            if (!bus.if_req_valid || i_gnt)
                cnt <= '0;
            else if (d_gnt && cnt != CW'(MAX_CONSEC))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
// Expected values are hand-computed from the initial memory image.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_CONSEC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    bit          loaded = 1'b0;

    always_comb bus.mem_read_data = mem[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 32'h0;
            mem[0]  <= 32'hDEADBEEF;
            mem[1]  <= 32'h12345678;
            mem[20] <= 32'h00000005;
            mem[30] <= 32'hFFFFFFFF;
            loaded  <= 1'b1;
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'h0;
        bus.d_req_valid  = 1'b0;
        bus.d_req_addr   = 32'h0;
        bus.d_req_we     = 1'b0;
        bus.d_req_wdata  = 32'h0;
    endtask

    task automatic dreq(input logic [31:0] a, input logic we,
                        input logic [31:0] wd);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_we    = we;
        bus.d_req_wdata = wd;
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("rst_if_rsp_valid", 32'(bus.if_rsp_valid), 32'h0);
        chk("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
        chk("rst_d_rsp_err", 32'(bus.d_rsp_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Fetch only
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0;
        #1;
        chk("f_if_ready", 32'(bus.if_req_ready), 32'h1);
        chk("f_d_ready", 32'(bus.d_req_ready), 32'h0);
        chk("f_mem_we", 32'(bus.mem_write_enable), 32'h0);
        tick();
        chk("f_rsp_valid", 32'(bus.if_rsp_valid), 32'h1);
        chk("f_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);
        idle();
        tick();
        chk("f_rsp_pulse", 32'(bus.if_rsp_valid), 32'h0);

        // Simultaneous fetch and load: data wins first
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h4;
        dreq(32'h50, 1'b0, 32'h0);
        #1;
        chk("c_d_ready", 32'(bus.d_req_ready), 32'h1);
        chk("c_if_ready", 32'(bus.if_req_ready), 32'h0);
        chk("c_mem_addr", bus.mem_address, 32'h50);
        tick();
        chk("c_d_rsp_valid", 32'(bus.d_rsp_valid), 32'h1);
        chk("c_d_rsp_data", bus.d_rsp_data, 32'h5);
        chk("c_if_rsp_none", 32'(bus.if_rsp_valid), 32'h0);
        bus.d_req_valid = 1'b0;
        #1;
        chk("c_if_ready2", 32'(bus.if_req_ready), 32'h1);
        tick();
        chk("c_if_rsp_valid", 32'(bus.if_rsp_valid), 32'h1);
        chk("c_if_rsp_data", bus.if_rsp_data, 32'h12345678);
        chk("c_d_rsp_pulse", 32'(bus.d_rsp_valid), 32'h0);

        // Both held high: D,D,D,D,F repeating
        bus.if_req_addr = 32'h0;
        dreq(32'h50, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("p_d_ready_%0d", i), 32'(bus.d_req_ready),
                (i % 5 == 4) ? 32'h0 : 32'h1);
            chk($sformatf("p_if_ready_%0d", i), 32'(bus.if_req_ready),
                (i % 5 == 4) ? 32'h1 : 32'h0);
            tick();
        end
        idle();
        tick();

        // Store then load
        dreq(32'h78, 1'b0, 32'h0);
        tick();
        chk("s_pre_load", bus.d_rsp_data, 32'hFFFFFFFF);
        dreq(32'h78, 1'b1, 32'h11223344);
        #1;
        chk("s_mem_we", 32'(bus.mem_write_enable), 32'h1);
        tick();
        chk("s_ack_valid", 32'(bus.d_rsp_valid), 32'h1);
        chk("s_ack_data", bus.d_rsp_data, 32'h0);
        chk("s_ack_err", 32'(bus.d_rsp_err), 32'h0);
        dreq(32'h78, 1'b0, 32'h0);
        tick();
        chk("s_load_back", bus.d_rsp_data, 32'h11223344);

        // Misaligned store
        dreq(32'h7A, 1'b1, 32'hAABBCCDD);
        #1;
        chk("m_ready", 32'(bus.d_req_ready), 32'h1);
        chk("m_mem_we", 32'(bus.mem_write_enable), 32'h0);
        tick();
        chk("m_valid", 32'(bus.d_rsp_valid), 32'h1);
        chk("m_err", 32'(bus.d_rsp_err), 32'h1);
        chk("m_data", bus.d_rsp_data, 32'h0);
        dreq(32'h78, 1'b0, 32'h0);
        tick();
        chk("m_err_clear", 32'(bus.d_rsp_err), 32'h0);
        chk("m_load_same", bus.d_rsp_data, 32'h11223344);

        // Reset in the middle of traffic
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h4;
        dreq(32'h40, 1'b1, 32'hCAFEF00D);
        tick();
        chk("r_pre_valid", 32'(bus.d_rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("r_d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
        chk("r_if_rsp_valid", 32'(bus.if_rsp_valid), 32'h0);
        chk("r_mem_we", 32'(bus.mem_write_enable), 32'h0);
        chk("r_d_ready", 32'(bus.d_req_ready), 32'h0);
        tick();
        idle();
        #1;
        rst_n = 1'b1;
        tick();
        chk("r_no_stale_d", 32'(bus.d_rsp_valid), 32'h0);
        chk("r_no_stale_if", 32'(bus.if_rsp_valid), 32'h0);
        chk("r_no_stale_err", 32'(bus.d_rsp_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
